uart_echo_tester: RTL and testbench
===================================

// Module: uart_echo_tester
// PURPOSE
//  Host-side initiator for the UART "echo +1" target. Drives a uart core's byte interface.
//  Streams a byte sequence out, checks each returned byte equals sent byte + 1, counts errors.
//  Flow control by outstanding window; detects a silent link by timeout; reports pass/fail.
//  Sits between a uart core instance (same byte-interface signals) and board LEDs / test top.
// PARAMETERS
//  NUM_BYTES        256        bytes per run, 1..65535
//  MAX_OUTSTANDING  8          max sent-but-unchecked bytes, 1..15 (target queue holds 15)
//  TIMEOUT_CYCLES   2700000    idle cycles with outstanding>0 before abort (100 ms @ 27 MHz)
//  SEED             8'h00      value of first transmitted byte
// PORTS
//  sys_clk              in   1   clock
//  sys_rst_n            in   1   asynchronous, active-low reset
//  start                in   1   1-cycle pulse: begin run (accepted in IDLE or DONE only)
//  uart_transmit        out  1   1-cycle pulse: send uart_tx_byte
//  uart_tx_byte         out  8   byte to send
//  uart_is_transmitting in   1   uart core tx busy
//  uart_received        in   1   1-cycle pulse: uart_rx_byte valid
//  uart_rx_byte         in   8   received byte
//  uart_recv_error      in   1   1-cycle pulse: framing error on rx
//  busy                 out  1   run in progress
//  done                 out  1   run finished (held until next start)
//  pass                 out  1   valid with done: err_count==0 and no timeout
//  timeout              out  1   run aborted by timeout (held until next start)
//  err_count            out  8   errors this run, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; uart_transmit low immediately (async).
//  Counters sent, checked: width $clog2(NUM_BYTES+1); outstanding = sent - checked.
//  Top FSM: IDLE -start-> RUN (clear sent/checked/err_count/timeout/done/pass, busy=1).
//   RUN -> DONE when checked==NUM_BYTES, or on timeout; DONE: busy=0, done=1, pass latched.
//   DONE -start-> RUN (restart). start in RUN ignored.
//  Tx FSM (only in RUN): T_IDLE -> T_PULSE when sent<NUM_BYTES, outstanding<MAX_OUTSTANDING,
//   uart_is_transmitting==0. T_PULSE: uart_transmit=1 for exactly 1 cycle,
//   uart_tx_byte = SEED + sent (mod 256), sent++ -> T_WAITHI.
//   T_WAITHI: wait uart_is_transmitting==1 -> T_WAITLO: wait ==0 -> T_IDLE.
//   uart_tx_byte held stable from T_PULSE until return to T_IDLE.
//   Min 1 idle cycle between successive pulses.
//  Rx check (only in RUN), on uart_received or uart_recv_error:
//   outstanding>0: expected = SEED + checked + 1 (mod 256); checked++;
//    err_count++ if recv_error, or rx_byte != expected. Both pulses same cycle = 1 error.
//   outstanding==0 (unsolicited byte): err_count++, checked unchanged.
//   Rx event and tx pulse in same cycle: both take effect; outstanding reflects both.
//  Timeout: counter cleared on tx pulse, rx event, or outstanding==0.
//   Increments otherwise; at TIMEOUT_CYCLES -> timeout=1, pass=0, go DONE.
//   An in-flight tx completes on the uart core; its echo is ignored (not in RUN).
//  err_count saturates at 8'hFF; no wrap.
//  Rx events in IDLE/DONE ignored.
//  pass = (err_count==0) & ~timeout, updated on entry to DONE.
// TESTING
//  1 +1 echo model, NUM_BYTES=4, SEED=8'h41: tx 41,42,43,44; rx 42..45
//    -> done=1, pass=1, err_count=0.
//  2 SEED=8'hFE, NUM_BYTES=3: tx FE,FF,00; echo FF,00,01
//    -> pass=1 (wrap at 256 correct).
//  3 echo model corrupts 2nd byte (returns 8'h00)
//    -> err_count=1, pass=0, done after all NUM_BYTES checked.
//  4 MAX_OUTSTANDING=3, echo delayed 10 frames
//    -> outstanding never >3, 4th uart_transmit waits for first echo.
//  5 echo drops 1 byte, TIMEOUT_CYCLES=1000
//    -> timeout=1 exactly 1000 cycles after last event, done=1, pass=0.
//  6 sys_rst_n low mid-run, then start pulse
//    -> outputs 0 during reset; new run restarts at SEED, passes.

Source files
------------

// File: rtl/uart_echo_tester.sv
// Host-side "echo +1" link tester: streams SEED+n bytes through a uart core, checks every
// echo equals the sent byte plus one inside a bounded outstanding window, and flags errors or silence.
module uart_echo_tester #(
    parameter int unsigned NUM_BYTES       = 256,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 2700000,
    parameter logic [7:0]  SEED            = 8'h00
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    output logic       uart_transmit,
    output logic [7:0] uart_tx_byte,
    input  logic       uart_is_transmitting,
    input  logic       uart_received,
    input  logic [7:0] uart_rx_byte,
    input  logic       uart_recv_error,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} topState_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_PULSE = 2'd1, T_WAITHI = 2'd2, T_WAITLO = 2'd3} txState_t;

    localparam int unsigned CW = $clog2(NUM_BYTES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    // The window compare is widened so MAX_OUTSTANDING is never truncated by a narrow counter.
    localparam int unsigned OW = (CW > 5) ? CW : 5;
    localparam logic [CW-1:0] NUM_C   = CW'(NUM_BYTES);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TONE_C  = TW'(1);

    topState_t     topState_r;
    txState_t      txState_r;
    logic [CW-1:0] sent_r;
    logic [CW-1:0] checked_r;
    logic [CW-1:0] outstanding_s;
    logic [CW-1:0] checkedNext_s;
    logic [OW-1:0] outWide_s;
    logic [TW-1:0] tmoCnt_r;
    logic [7:0]    errNext_s;
    logic [7:0]    expected_s;
    logic [7:0]    sentLow_s;
    logic [7:0]    checkedLow_s;
    logic          rxEvent_s;
    logic          rxBad_s;
    logic          tmoClear_s;
    logic          tmoExpire_s;
    logic          launch_s;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Derived counts, rx event qualification and the launch / abort conditions
    always_comb begin
        outstanding_s = sent_r - checked_r;
        outWide_s     = OW'(outstanding_s);
        sentLow_s     = 8'(sent_r);
        checkedLow_s  = 8'(checked_r);
        expected_s    = SEED + checkedLow_s + 8'd1;
        rxEvent_s     = (topState_r == S_RUN) && (uart_received || uart_recv_error);
        rxBad_s       = uart_recv_error || (uart_rx_byte != expected_s);
        tmoClear_s    = uart_transmit || rxEvent_s || (outstanding_s == '0);
        tmoExpire_s   = (topState_r == S_RUN) && !tmoClear_s && (tmoCnt_r == TLAST_C);
        launch_s      = (topState_r == S_RUN) && (txState_r == T_IDLE) && (sent_r < NUM_C) &&
                        (outWide_s < MAXO_C) && !uart_is_transmitting && !tmoExpire_s;
    end

    // Next check count and error count; a byte with no send pending is an error but not a check
    always_comb begin
        checkedNext_s = checked_r;
        errNext_s     = err_count;
        if (rxEvent_s) begin
            if (outstanding_s != '0) begin
                checkedNext_s = checked_r + ONE_C;
                if (rxBad_s) begin
                    errNext_s = satInc8(err_count);
                end else begin
                    errNext_s = err_count;
                end
            end else begin
                errNext_s = satInc8(err_count);
            end
        end else begin
            checkedNext_s = checked_r;
        end
    end

    // Run control, transmit sequencing, echo checking and the silence watchdog
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            topState_r    <= S_IDLE;
            txState_r     <= T_IDLE;
            sent_r        <= '0;
            checked_r     <= '0;
            tmoCnt_r      <= '0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= 8'h00;
        end else begin
            uart_transmit <= 1'b0;
            case (topState_r)
                S_IDLE, S_DONE: begin
                    txState_r <= T_IDLE;
                    if (start) begin
                        topState_r <= S_RUN;
                        sent_r     <= '0;
                        checked_r  <= '0;
                        tmoCnt_r   <= '0;
                        err_count  <= 8'h00;
                        timeout    <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    case (txState_r)
                        T_IDLE: begin
                            if (launch_s) begin
                                txState_r     <= T_PULSE;
                                uart_transmit <= 1'b1;
                                uart_tx_byte  <= SEED + sentLow_s;
                                sent_r        <= sent_r + ONE_C;
                            end
                        end
                        T_PULSE:  txState_r <= T_WAITHI;
                        T_WAITHI: if (uart_is_transmitting) txState_r <= T_WAITLO;
                        T_WAITLO: if (!uart_is_transmitting) txState_r <= T_IDLE;
                        default:  txState_r <= T_IDLE;
                    endcase
                    checked_r <= checkedNext_s;
                    err_count <= errNext_s;
                    if (tmoClear_s) begin
                        tmoCnt_r <= '0;
                    end else begin
                        tmoCnt_r <= tmoCnt_r + TONE_C;
                    end
                    if (checkedNext_s == NUM_C) begin
                        topState_r <= S_DONE;
                        txState_r  <= T_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (errNext_s == 8'h00);
                    end else if (tmoExpire_s) begin
                        topState_r <= S_DONE;
                        txState_r  <= T_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                        pass       <= 1'b0;
                    end
                end
                default: topState_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: two instances (different SEED/size) driven by a
// uart-core + echo-target model that can delay, corrupt, flag or drop individual echoes.
module tb_uart_echo_tester;

    localparam int FRAME = 10;
    localparam int TMO   = 1000;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] start;
    logic [1:0] uTx;
    logic [7:0] txByte [2];
    logic [1:0] isTx = 2'b00;
    logic [1:0] mRx = 2'b00;
    logic [1:0] injRx;
    logic [1:0] rxPulse;
    logic [7:0] rxByte [2];
    logic [1:0] rxErr = 2'b00;
    logic [1:0] busy, done, pass, tmo;
    logic [7:0] errCnt [2];
    logic [1:0] runClr;

    int cyc = 0;
    int passCnt = 0;
    int totalCnt = 0;

    // echo-target configuration (bench owned) and per-run observations (model owned)
    int dly [2], cor [2], drp [2], bad [2];
    int dueQ [2][$];
    int idxQ [2][$];
    logic [7:0] byteQ [2][$];
    int txLeft [2], curIdx [2];
    logic [7:0] curByte [2];
    int txRun [2], rxRun [2], maxOut [2], lastEvt [2], firstEcho [2];
    logic [7:0] txLog [2][8];
    int txCyc [2][8];

    assign rxPulse = mRx | injRx;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_echo_tester #(.NUM_BYTES(4), .MAX_OUTSTANDING(3), .TIMEOUT_CYCLES(TMO), .SEED(8'h41)) dutA (
        .sys_clk(clk), .sys_rst_n(rstN), .start(start[0]),
        .uart_transmit(uTx[0]), .uart_tx_byte(txByte[0]), .uart_is_transmitting(isTx[0]),
        .uart_received(rxPulse[0]), .uart_rx_byte(rxByte[0]), .uart_recv_error(rxErr[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]), .err_count(errCnt[0])
    );

    uart_echo_tester #(.NUM_BYTES(3), .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(TMO), .SEED(8'hFE)) dutB (
        .sys_clk(clk), .sys_rst_n(rstN), .start(start[1]),
        .uart_transmit(uTx[1]), .uart_tx_byte(txByte[1]), .uart_is_transmitting(isTx[1]),
        .uart_received(rxPulse[1]), .uart_rx_byte(rxByte[1]), .uart_recv_error(rxErr[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]), .err_count(errCnt[1])
    );

    // uart core (FRAME-cycle busy per byte) plus echo target returning byte+1 after dly cycles
    always @(negedge clk) begin
        int idx;
        logic [7:0] b;
        for (int g = 0; g < 2; g++) begin
            mRx[g] = 1'b0;
            rxErr[g] = 1'b0;
            if (!rstN) begin
                dueQ[g].delete();
                idxQ[g].delete();
                byteQ[g].delete();
                txLeft[g] = 0;
                isTx[g] = 1'b0;
                rxByte[g] = 8'h00;
            end else begin
                if (runClr[g]) begin
                    txRun[g] = 0;
                    rxRun[g] = 0;
                    maxOut[g] = 0;
                    firstEcho[g] = -1;
                end
                if (txLeft[g] > 0) begin
                    txLeft[g]--;
                    if (txLeft[g] == 0) begin
                        isTx[g] = 1'b0;
                        dueQ[g].push_back(cyc + 1 + dly[g]);
                        idxQ[g].push_back(curIdx[g]);
                        byteQ[g].push_back(curByte[g]);
                    end
                end
                if (uTx[g]) begin
                    txLeft[g] = FRAME;
                    isTx[g] = 1'b1;
                    curIdx[g] = txRun[g];
                    curByte[g] = txByte[g];
                    if (txRun[g] < 8) begin
                        txLog[g][txRun[g]] = txByte[g];
                        txCyc[g][txRun[g]] = cyc;
                    end
                    txRun[g]++;
                    lastEvt[g] = cyc;
                end
                if (dueQ[g].size() > 0) begin
                    if (dueQ[g][0] <= cyc) begin
                        void'(dueQ[g].pop_front());
                        idx = idxQ[g].pop_front();
                        b = byteQ[g].pop_front();
                        if (idx != drp[g]) begin
                            mRx[g] = 1'b1;
                            rxByte[g] = (idx == cor[g]) ? 8'h00 : b + 8'd1;
                            rxErr[g] = (idx == bad[g]);
                            rxRun[g]++;
                            lastEvt[g] = cyc;
                            if (firstEcho[g] < 0) firstEcho[g] = cyc;
                        end
                    end
                end
                if (txRun[g] - rxRun[g] > maxOut[g]) maxOut[g] = txRun[g] - rxRun[g];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic runStart(input int g, input bit inj);
        runClr[g] = 1'b1;
        tick();
        runClr[g] = 1'b0;
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        injRx[g] = inj;
        tick();
        injRx[g] = 1'b0;
    endtask

    task automatic waitDone(input int g, input int limit, output int atCyc, output int ok);
        int n;
        n = 0;
        ok = 0;
        atCyc = -1;
        while (ok == 0 && n < limit) begin
            tick();
            n++;
            if (done[g]) begin
                ok = 1;
                atCyc = cyc;
            end
        end
    endtask

    task automatic checkQuiet(input string name, input int g);
        check({name, "/flags"}, int'({busy[g], done[g], pass[g], tmo[g], uTx[g]}), 0);
        check({name, "/err"}, int'(errCnt[g]), 0);
        check({name, "/txbyte"}, int'(txByte[g]), 0);
    endtask

    typedef struct {
        string       name;
        int          ch;
        int          dly;
        int          cor;
        int          drp;
        int          bad;
        bit          inj;
        int          nExp;
        logic [31:0] eBytes;
        bit          eTmo;
        bit          ePass;
        int          eErr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int g, dc, ok;
        vecs[0] = '{"basic",     0, 0, -1, -1, -1, 1'b0, 4, 32'h41424344, 1'b0, 1'b1, 0};
        vecs[1] = '{"wrap",      1, 0, -1, -1, -1, 1'b0, 3, 32'hFEFF0000, 1'b0, 1'b1, 0};
        vecs[2] = '{"corrupt2",  0, 0,  1, -1, -1, 1'b0, 4, 32'h41424344, 1'b0, 1'b0, 1};
        vecs[3] = '{"rxerr3",    0, 0, -1, -1,  2, 1'b0, 4, 32'h41424344, 1'b0, 1'b0, 1};
        vecs[4] = '{"unsolicit", 0, 0, -1, -1, -1, 1'b1, 4, 32'h41424344, 1'b0, 1'b0, 1};
        vecs[5] = '{"drop4",     0, 0, -1,  3, -1, 1'b0, 4, 32'h41424344, 1'b1, 1'b0, 0};
        vecs[6] = '{"corbad1",   1, 0,  0, -1,  0, 1'b0, 3, 32'hFEFF0000, 1'b0, 1'b0, 1};

        rstN = 1'b0;
        start = 2'b00;
        injRx = 2'b00;
        runClr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            dly[i] = 0; cor[i] = -1; drp[i] = -1; bad[i] = -1;
        end
        repeat (3) tick();
        checkQuiet("reset_a", 0);
        checkQuiet("reset_b", 1);
        rstN = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            g = vecs[i].ch;
            dly[g] = vecs[i].dly;
            cor[g] = vecs[i].cor;
            drp[g] = vecs[i].drp;
            bad[g] = vecs[i].bad;
            runStart(g, vecs[i].inj);
            waitDone(g, 3000, dc, ok);
            check({vecs[i].name, "/done"}, ok, 1);
            check({vecs[i].name, "/busy"}, int'(busy[g]), 0);
            check({vecs[i].name, "/timeout"}, int'(tmo[g]), int'(vecs[i].eTmo));
            check({vecs[i].name, "/pass"}, int'(pass[g]), int'(vecs[i].ePass));
            check({vecs[i].name, "/err_count"}, int'(errCnt[g]), vecs[i].eErr);
            check({vecs[i].name, "/tx_count"}, txRun[g], vecs[i].nExp);
            for (int k = 0; k < vecs[i].nExp; k++) begin
                check({vecs[i].name, "/tx_byte"}, int'(txLog[g][k]), int'(vecs[i].eBytes[31-8*k -: 8]));
            end
            if (vecs[i].eTmo) begin
                // TMO idle cycles after the last pulse cycle, then the flag appears
                check({vecs[i].name, "/timeout_latency"}, dc - lastEvt[g], TMO + 1);
            end
            repeat (5) tick();
        end
        dly[0] = 0; cor[0] = -1; drp[0] = -1; bad[0] = -1;
        dly[1] = 0; cor[1] = -1; drp[1] = -1; bad[1] = -1;

        // slow echo: window of 3 fills, 4th send must wait for the first echo
        dly[0] = 100;
        runStart(0, 1'b0);
        waitDone(0, 3000, dc, ok);
        check("window/done", ok, 1);
        check("window/pass", int'(pass[0]), 1);
        check("window/max_outstanding", maxOut[0], 3);
        check("window/4th_after_echo", (txCyc[0][3] > firstEcho[0]) ? 1 : 0, 1);
        dly[0] = 0;
        repeat (5) tick();

        // start while running is ignored
        runStart(0, 1'b0);
        repeat (6) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        waitDone(0, 3000, dc, ok);
        check("restart_ignored/done", ok, 1);
        check("restart_ignored/pass", int'(pass[0]), 1);
        check("restart_ignored/tx_count", txRun[0], 4);

        // rx events in DONE leave the result alone
        injRx[0] = 1'b1;
        tick();
        injRx[0] = 1'b0;
        repeat (2) tick();
        check("done_rx/err_count", int'(errCnt[0]), 0);
        check("done_rx/done", int'(done[0]), 1);
        check("done_rx/pass", int'(pass[0]), 1);

        // reset in the middle of a run, then a clean run from SEED
        runStart(0, 1'b0);
        repeat (15) tick();
        check("midreset/busy_before", int'(busy[0]), 1);
        rstN = 1'b0;
        #1;
        checkQuiet("midreset_async", 0);
        repeat (3) tick();
        checkQuiet("midreset_held", 0);
        rstN = 1'b1;
        repeat (3) tick();
        runStart(0, 1'b0);
        waitDone(0, 3000, dc, ok);
        check("midreset/done", ok, 1);
        check("midreset/pass", int'(pass[0]), 1);
        check("midreset/first_byte", int'(txLog[0][0]), 8'h41);
        check("midreset/tx_count", txRun[0], 4);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passCnt, totalCnt);
        $fatal(1, "watchdog");
    end

endmodule
